// File: rtl/packet_framer.sv
// Packet framer: prefixes each payload with an 8-byte {length, stream, seq}
// header and stamps it from a per-stream sequence counter.
module packet_framer #(
  parameter int NUM_STREAMS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cmd_stream,
  input  logic [15:0] cmd_length,
  input  logic        cmd_val,
  output logic        cmd_ready,
  output logic        cmd_err,
  input  logic [31:0] pay_data,
  input  logic        pay_val,
  output logic        pay_ready,
  output logic [31:0] out_data,
  output logic        out_val,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int IW = $clog2(NUM_STREAMS);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, PAY} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    rem_q;
  logic [15:0]   left_q;
  logic [31:0]   seq_q [NUM_STREAMS];
  logic [31:0]   data_q;
  logic          val_q;
  logic          last_q;
  logic          err_q;

  logic          out_acc;
  logic          pay_acc;
  logic [31:0]   seq_rd;
  logic [31:0]   pay_mask;
  logic [16:0]   len_p3;
  logic [15:0]   left_d;

  assign cmd_ready = (state_q == IDLE) && !reset;
  // left_q gating keeps the next packet's words out of this one
  assign pay_ready = (state_q == PAY) && (left_q != 16'd0)
                   && (!val_q || out_ready);
  assign out_acc   = val_q && out_ready;
  assign pay_acc   = pay_val && pay_ready;
  assign seq_rd    = seq_q[idx_q];
  assign len_p3    = {1'b0, cmd_length} + 17'd3;
  assign left_d    = {1'b0, len_p3[16:2]} - 16'd2;

  assign out_data  = data_q;
  assign out_val   = val_q;
  assign out_last  = last_q;
  assign cmd_err   = err_q;

  always_comb begin
    pay_mask = 32'hFFFF_FFFF;
    case (rem_q)
      2'd1:    pay_mask = 32'hFF00_0000;
      2'd2:    pay_mask = 32'hFFFF_0000;
      2'd3:    pay_mask = 32'hFFFF_FF00;
      default: pay_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      left_q  <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        seq_q[i] <= 32'd1;
      end
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_val) begin
            if (cmd_length < 16'd8) begin
              err_q <= 1'b1;
            end else begin
              idx_q   <= cmd_stream[IW-1:0];
              rem_q   <= cmd_length[1:0];
              left_q  <= left_d;
              data_q  <= {cmd_length[7:0], cmd_length[15:8],
                          cmd_stream[7:0], cmd_stream[15:8]};
              val_q   <= 1'b1;
              last_q  <= 1'b0;
              state_q <= HDR0;
            end
          end
        end
        HDR0: begin
          if (out_acc) begin
            data_q  <= {seq_rd[7:0], seq_rd[15:8],
                        seq_rd[23:16], seq_rd[31:24]};
            last_q  <= (left_q == 16'd0);
            state_q <= HDR1;
          end
        end
        HDR1: begin
          if (out_acc) begin
            seq_q[idx_q] <= seq_rd + 32'd1;
            val_q        <= 1'b0;
            last_q       <= 1'b0;
            state_q      <= (left_q == 16'd0) ? IDLE : PAY;
          end
        end
        PAY: begin
          if (pay_acc) begin
            data_q <= (left_q == 16'd1) ? (pay_data & pay_mask)
                                        : pay_data;
            val_q  <= 1'b1;
            last_q <= (left_q == 16'd1);
            left_q <= left_q - 16'd1;
          end else if (out_acc) begin
            val_q  <= 1'b0;
            last_q <= 1'b0;
            if (last_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_packet_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cmd_stream = '0;
  logic [15:0] cmd_length = '0;
  logic        cmd_val = 1'b0;
  logic        cmd_ready;
  logic        cmd_err;
  logic [31:0] pay_data = '0;
  logic        pay_val = 1'b0;
  logic        pay_ready;
  logic [31:0] out_data;
  logic        out_val;
  logic        out_ready = 1'b1;
  logic        out_last;

  packet_framer #(.NUM_STREAMS(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_stream(cmd_stream), .cmd_length(cmd_length),
    .cmd_val(cmd_val), .cmd_ready(cmd_ready), .cmd_err(cmd_err),
    .pay_data(pay_data), .pay_val(pay_val), .pay_ready(pay_ready),
    .out_data(out_data), .out_val(out_val),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  typedef struct {
    logic [15:0] s;
    logic [15:0] len;
    logic [31:0] base;
    logic [31:0] inc;
    logic [31:0] h0;
    logic [31:0] h1;
    logic [31:0] lastw;
    int          nw;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_cnt = 0;
  int          exp_err = 0;
  int          rdy_mode = 1;
  bit          pay_gap = 1'b0;
  word_t       got_q[$];
  int          got_cyc[$];
  word_t       exp_q[$];
  logic [31:0] pay_q[$];
  logic [31:0] mpay_q[$];
  logic [31:0] mseq[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 0) out_ready = 1'b0;
    else if (rdy_mode == 1) out_ready = 1'b1;
    else out_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    bit consumed;
    forever begin
      @(negedge clk);
      consumed = pay_val && pay_ready && !reset;
      @(posedge clk);
      #3;
      if (consumed && pay_q.size() > 0) void'(pay_q.pop_front());
      if (pay_q.size() > 0 && (!pay_gap || $urandom_range(0, 3) != 0)) begin
        pay_val  = 1'b1;
        pay_data = pay_q[0];
      end else begin
        pay_val  = 1'b0;
        pay_data = $urandom;
      end
    end
  end

  initial begin
    logic        hold;
    logic [31:0] hd;
    logic        hl;
    hold = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold) begin
          chk("hold_val", 32'(out_val), 32'd1);
          chk("hold_data", out_data, hd);
          chk("hold_last", 32'(out_last), 32'(hl));
        end
        if (out_val && out_ready) begin
          got_q.push_back('{out_data, out_last});
          got_cyc.push_back(cyc);
        end
        if (cmd_err) err_cnt++;
        hold = out_val && !out_ready;
        hd   = out_data;
        hl   = out_last;
      end else begin
        hold = 1'b0;
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mseq[i] = 32'd1;
  endfunction

  function automatic void model_cmd(input logic [15:0] s,
                                    input logic [15:0] l);
    int          n;
    int          keep;
    int          idx;
    logic [31:0] w;
    logic [31:0] sq;
    if (l < 16'd8) begin
      exp_err++;
      return;
    end
    idx  = int'(s) % 16;
    n    = (int'(l) + 3) / 4 - 2;
    keep = (int'(l) % 4 == 0) ? 4 : int'(l) % 4;
    exp_q.push_back('{{l[7:0], l[15:8], s[7:0], s[15:8]}, 1'b0});
    sq = mseq[idx];
    exp_q.push_back('{{sq[7:0], sq[15:8], sq[23:16], sq[31:24]}, n == 0});
    mseq[idx] = sq + 32'd1;
    for (int k = 0; k < n; k++) begin
      w = mpay_q.pop_front();
      if (k == n - 1)
        for (int b = keep; b < 4; b++) w[8*(3-b) +: 8] = 8'h00;
      exp_q.push_back('{w, k == n - 1});
    end
  endfunction

  function automatic word_t gw(input int i);
    if (i < got_q.size()) return got_q[i];
    return '{32'hBAD0_BAD0, 1'b0};
  endfunction

  task automatic send_cmd(input logic [15:0] s, input logic [15:0] l,
                          output int acc_cyc);
    int n;
    n          = 0;
    acc_cyc    = -1;
    cmd_stream = s;
    cmd_length = l;
    cmd_val    = 1'b1;
    while (n < 3000) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_cyc = cyc;
        break;
      end
      n++;
    end
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
    if (acc_cyc < 0) chk("cmd_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_last();
    int t;
    bit seen;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 3000) begin
      @(posedge clk);
      #1;
      foreach (got_q[i]) if (got_q[i].l) seen = 1'b1;
      t++;
    end
    if (!seen) chk("last_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_pay(input logic [31:0] w);
    pay_q.push_back(w);
    mpay_q.push_back(w);
  endtask

  task automatic run_pkt(input logic [15:0] s, input logic [15:0] l,
                         input logic [31:0] base, input logic [31:0] inc,
                         output int acc_cyc);
    int n;
    n = (l >= 16'd8) ? (int'(l) + 3) / 4 - 2 : 0;
    for (int k = 0; k < n; k++) push_pay(base + inc * 32'(k));
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    model_cmd(s, l);
    send_cmd(s, l, acc_cyc);
    if (l >= 16'd8) wait_last();
  endtask

  task automatic cmp_all(input string tag);
    word_t w;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      w = gw(i);
      chk($sformatf("%s_w%0d_data", tag, i), w.d, exp_q[i].d);
      chk($sformatf("%s_w%0d_last", tag, i), 32'(w.l), 32'(exp_q[i].l));
    end
  endtask

  initial begin
    vec_t        tv[6];
    int          acc;
    int          base_err;
    int          nl;
    int          psz;
    int          t;
    logic [31:0] held;
    logic [15:0] rs;
    logic [15:0] rl;
    int          rn;

    model_reset();
    tv[0] = '{16'd12, 16'd20, 32'h0123_4562, 32'd1,
              32'h1400_0C00, 32'h0100_0000, 32'h0123_4564, 5};
    tv[1] = '{16'd13, 16'd25, 32'hAABB_CCDD, 32'd0,
              32'h1900_0D00, 32'h0100_0000, 32'hAA00_0000, 7};
    tv[2] = '{16'd12, 16'd39, 32'hAABB_CCDD, 32'd0,
              32'h2700_0C00, 32'h0200_0000, 32'hAABB_CC00, 10};
    tv[3] = '{16'd5, 16'd8, 32'h0, 32'd0,
              32'h0800_0500, 32'h0100_0000, 32'h0100_0000, 2};
    tv[4] = '{16'h1234, 16'd12, 32'hDEAD_BEEF, 32'd0,
              32'h0C00_3412, 32'h0100_0000, 32'hDEAD_BEEF, 3};
    tv[5] = '{16'h0105, 16'd258, 32'h1122_3344, 32'd0,
              32'h0201_0501, 32'h0200_0000, 32'h1122_0000, 65};

    @(negedge clk);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_pay_ready", 32'(pay_ready), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_pkt(tv[i].s, tv[i].len, tv[i].base, tv[i].inc, acc);
      chk($sformatf("tv%0d_nwords", i), 32'(got_q.size()), 32'(tv[i].nw));
      chk($sformatf("tv%0d_hdr0", i), gw(0).d, tv[i].h0);
      chk($sformatf("tv%0d_hdr1", i), gw(1).d, tv[i].h1);
      chk($sformatf("tv%0d_lastw", i), gw(tv[i].nw - 1).d, tv[i].lastw);
      chk($sformatf("tv%0d_lastflag", i), 32'(gw(tv[i].nw - 1).l), 32'd1);
      nl = 0;
      foreach (got_q[k]) if (got_q[k].l) nl++;
      chk($sformatf("tv%0d_nlast", i), 32'(nl), 32'd1);
      if (i == 0) begin
        chk("hdr0_latency", 32'(got_cyc[0] - acc), 32'd1);
        chk("word5_delay", 32'(got_cyc[4] - got_cyc[0]), 32'd5);
      end
      cmp_all($sformatf("tv%0d", i));
    end

    got_q.delete();
    base_err = err_cnt;
    model_cmd(16'd5, 16'd6);
    send_cmd(16'd5, 16'd6, acc);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("err_pulse_cycles", 32'(err_cnt - base_err), 32'd1);
    chk("err_no_output", 32'(got_q.size()), 32'd0);
    run_pkt(16'd5, 16'd8, 32'h0, 32'd0, acc);
    chk("seq5_after_err", gw(1).d, 32'h0300_0000);
    chk("seq5_hdr_last", 32'(gw(1).l), 32'd1);

    for (int k = 0; k < 4; k++) push_pay(32'hB000_0000 + 32'(k));
    got_q.delete();
    exp_q.delete();
    model_cmd(16'd3, 16'd24);
    send_cmd(16'd3, 16'd24, acc);
    t = 0;
    while (got_q.size() < 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_reach", 32'(got_q.size() >= 3), 32'd1);
    rdy_mode = 0;
    psz  = 0;
    held = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_pay_ready", 32'(pay_ready), 32'd0);
      chk("bp_out_val", 32'(out_val), 32'd1);
      if (j == 0) begin
        held = out_data;
        psz  = pay_q.size();
      end else begin
        chk("bp_data_stable", out_data, held);
      end
    end
    chk("bp_no_consume", 32'(pay_q.size()), 32'(psz));
    @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_last();
    cmp_all("bp");

    for (int k = 0; k < 8; k++) pay_q.push_back(32'hC000_0000 + 32'(k));
    got_q.delete();
    send_cmd(16'd12, 16'd40, acc);
    t = 0;
    while (got_q.size() < 4 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_out_val", 32'(out_val), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    pay_q.delete();
    mpay_q.delete();
    exp_q.delete();
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mid_rst_no_output", 32'(got_q.size()), 32'd4);
    run_pkt(16'd12, 16'd12, 32'h5555_0001, 32'd0, acc);
    chk("post_rst_hdr0", gw(0).d, 32'h0C00_0C00);
    chk("post_rst_hdr1", gw(1).d, 32'h0100_0000);
    cmp_all("post_rst");

    rdy_mode = 2;
    pay_gap  = 1'b1;
    got_q.delete();
    exp_q.delete();
    base_err = err_cnt;
    exp_err  = 0;
    for (int p = 0; p < 60; p++) begin
      rs = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rl = 16'($urandom_range(0, 7));
      else rl = 16'($urandom_range(8, 90));
      rn = (rl >= 16'd8) ? (int'(rl) + 3) / 4 - 2 : 0;
      for (int k = 0; k < rn; k++) push_pay($urandom);
      model_cmd(rs, rl);
      send_cmd(rs, rl, acc);
    end
    t = 0;
    while (got_q.size() < exp_q.size() && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    cmp_all("rand");
    chk("rand_err_count", 32'(err_cnt - base_err), 32'(exp_err));
    chk("rand_pay_drained", 32'(pay_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
